fft_peak_detect: RTL and testbench

//  Frame-level spectral peak detector placed directly downstream of the bit-reversal reorder buffer.

---
 rtl/fft_peak_detect.sv | 191 +++++++++++++++++++
 tb/tb_fft_peak_detect.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: tracks the largest |X|^2 bin over each 2^N-point frame of a
// natural-order FFT stream and reports it once per completed frame.
// Optional feature macro: FFT_PEAK_SKIP_DC_EN (exclude bin 0 from the search).
module fft_peak_detect #(
  parameter int unsigned width = 16,
  parameter int unsigned N     = 9
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    en_in,
  input  logic [N-1:0]            cnt_in,
  input  logic signed [width-1:0] din_re,
  input  logic signed [width-1:0] din_im,
  output logic                    peak_valid,
  output logic [N-1:0]            peak_bin,
  output logic [2*width:0]        peak_pow,
  output logic [15:0]             frame_cnt,
  output logic                    frame_err
);

  localparam int unsigned PW    = 2 * width + 1;
  localparam int unsigned PRODW = 2 * width;
  localparam logic [N-1:0] LAST_BIN = '1;
`ifdef FFT_PEAK_SKIP_DC_EN
  localparam logic [N-1:0] FIRST_BIN = N'(1);
`else
  localparam logic [N-1:0] FIRST_BIN = '0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DONE, S_WAIT} state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_en_prev;
  logic [N-1:0]             r_prev_cnt;
  logic [N-1:0]             w_cnt_exp;
  logic                     w_accept, w_err;

  logic signed [PRODW-1:0]  w_re_ext, w_im_ext, w_sq_re, w_sq_im;
  logic                     r_v1, r_last1, r_v2, r_last2;
  logic [N-1:0]             r_bin1, r_bin2;
  logic signed [PRODW-1:0]  r_sq_re, r_sq_im;
  logic [PW-1:0]            r_pow2;

  logic [PW-1:0]            r_max_pow, w_max_pow;
  logic [N-1:0]             r_max_bin, w_max_bin;
  logic                     w_cand, w_load;

  logic                     r_peak_valid, r_frame_err;
  logic [N-1:0]             r_peak_bin;
  logic [PW-1:0]            r_peak_pow;
  logic [15:0]              r_frame_cnt;

  assign w_cnt_exp = r_prev_cnt + N'(1);
  assign w_re_ext  = {{width{din_re[width-1]}}, din_re};
  assign w_im_ext  = {{width{din_im[width-1]}}, din_im};
  assign w_sq_re   = w_re_ext * w_re_ext;
  assign w_sq_im   = w_im_ext * w_im_ext;

  // FSM state register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state, sample acceptance and framing-error detection
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: if (en_in && !r_en_prev) w_state_nxt = S_ARM;
      S_ARM: begin
        if (!en_in) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (cnt_in != '0) begin
          w_err       = 1'b1;
          w_state_nxt = S_WAIT;
        end else begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!en_in) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (cnt_in != w_cnt_exp) begin
          w_err       = 1'b1;
          w_state_nxt = S_WAIT;
        end else begin
          w_accept = 1'b1;
          if (cnt_in == LAST_BIN) w_state_nxt = S_DONE;
        end
      end
      // pipeline drains on its own; a conforming upstream is low here
      S_DONE: w_state_nxt = en_in ? S_WAIT : S_IDLE;
      S_WAIT: if (!en_in) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Edge detect on en_in and last accepted bin index
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_en_prev  <= 1'b1;
      r_prev_cnt <= '0;
    end else begin
      r_en_prev <= en_in;
      if (w_accept) r_prev_cnt <= cnt_in;
    end
  end

  // S1: square real and imaginary parts
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_bin1  <= '0;
      r_sq_re <= '0;
      r_sq_im <= '0;
    end else begin
      r_v1    <= w_accept;
      r_last1 <= w_accept && (cnt_in == LAST_BIN);
      if (w_accept) begin
        r_bin1  <= cnt_in;
        r_sq_re <= w_sq_re;
        r_sq_im <= w_sq_im;
      end
    end
  end

  // S2: sum of squares as unsigned power; a framing error flushes in-flight bins
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
      r_bin2  <= '0;
      r_pow2  <= '0;
    end else begin
      r_v2    <= r_v1 && !w_err;
      r_last2 <= r_last1 && !w_err;
      if (r_v1) begin
        r_bin2 <= r_bin1;
        r_pow2 <= PW'($unsigned(r_sq_re)) + PW'($unsigned(r_sq_im));
      end
    end
  end

  // S3 compare: strict greater keeps the lower bin on ties
  always_comb begin
`ifdef FFT_PEAK_SKIP_DC_EN
    w_cand = (r_bin2 != '0);
`else
    w_cand = 1'b1;
`endif
    w_load    = r_v2 && w_cand && ((r_bin2 == FIRST_BIN) || (r_pow2 > r_max_pow));
    w_max_pow = w_load ? r_pow2 : r_max_pow;
    w_max_bin = w_load ? r_bin2 : r_max_bin;
  end

  // S3 running max and per-frame reporting
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_max_pow    <= '0;
      r_max_bin    <= '0;
      r_peak_valid <= 1'b0;
      r_peak_bin   <= '0;
      r_peak_pow   <= '0;
      r_frame_cnt  <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_max_pow    <= w_max_pow;
      r_max_bin    <= w_max_bin;
      r_peak_valid <= r_v2 && r_last2;
      r_frame_err  <= w_err;
      if (r_v2 && r_last2) begin
        r_peak_bin  <= w_max_bin;
        r_peak_pow  <= w_max_pow;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign peak_valid = r_peak_valid;
  assign peak_bin   = r_peak_bin;
  assign peak_pow   = r_peak_pow;
  assign frame_cnt  = r_frame_cnt;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect (honours FFT_PEAK_SKIP_DC_EN).
module tb_fft_peak_detect;

`ifdef FFT_PEAK_SKIP_DC_EN
  localparam bit SKIP_DC = 1'b1;
`else
  localparam bit SKIP_DC = 1'b0;
`endif

  logic               clk;
  logic               areset;
  logic               en_in;
  logic [8:0]         cnt_in;
  logic signed [15:0] din_re, din_im;
  logic               peak_valid;
  logic [8:0]         peak_bin;
  logic [32:0]        peak_pow;
  logic [15:0]        frame_cnt;
  logic               frame_err;

  fft_peak_detect #(.width(16), .N(9)) dut (
    .clk(clk), .areset(areset), .en_in(en_in), .cnt_in(cnt_in),
    .din_re(din_re), .din_im(din_im), .peak_valid(peak_valid),
    .peak_bin(peak_bin), .peak_pow(peak_pow), .frame_cnt(frame_cnt),
    .frame_err(frame_err)
  );

  typedef struct {
    int          due;
    logic [8:0]  bin;
    logic [32:0] pow;
    logic [15:0] cnt;
  } exp_t;

  exp_t               exp_q[$];
  int                 err_q[$];
  int                 n_cmp = 0;
  int                 n_fail = 0;
  int                 cyc = 0;
  logic [15:0]        exp_cnt = 16'd0;
  logic signed [15:0] fr_re [512];
  logic signed [15:0] fr_im [512];
  exp_t               mon_e;
  int                 mon_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: match peak_valid / frame_err pulses against the scoreboard
  always @(negedge clk) begin
    if (!areset) begin
      if (peak_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_peak_valid cycle=%0d bin=%0d pow=%0d", cyc, peak_bin, peak_pow);
        end else begin
          mon_e = exp_q.pop_front();
          if (cyc !== mon_e.due || peak_bin !== mon_e.bin || peak_pow !== mon_e.pow ||
              frame_cnt !== mon_e.cnt) begin
            n_fail++;
            $display("FAIL peak cycle=%0d/%0d bin=%0d/%0d pow=%0d/%0d cnt=%0d/%0d (got/exp)",
                     cyc, mon_e.due, peak_bin, mon_e.bin, peak_pow, mon_e.pow, frame_cnt, mon_e.cnt);
          end
        end
      end
      if (frame_err) begin
        n_cmp++;
        if (err_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_frame_err cycle=%0d", cyc);
        end else begin
          mon_d = err_q.pop_front();
          if (cyc !== mon_d) begin
            n_fail++;
            $display("FAIL frame_err_timing cycle got=%0d exp=%0d", cyc, mon_d);
          end
        end
      end
    end
  end

  task automatic clear_frame();
    for (int i = 0; i < 512; i++) begin
      fr_re[i] = 16'sd0;
      fr_im[i] = 16'sd0;
    end
  endtask

  // Independent reference: max power, lowest bin on ties
  task automatic model(output logic [8:0] eb, output logic [32:0] ep);
    longint best, p;
    int     start;
    start = SKIP_DC ? 1 : 0;
    best  = longint'(fr_re[start]) * longint'(fr_re[start]) +
            longint'(fr_im[start]) * longint'(fr_im[start]);
    eb    = 9'(start);
    for (int b = start + 1; b < 512; b++) begin
      p = longint'(fr_re[b]) * longint'(fr_re[b]) + longint'(fr_im[b]) * longint'(fr_im[b]);
      if (p > best) begin
        best = p;
        eb   = 9'(b);
      end
    end
    ep = 33'(best);
  endtask

  // mode 0 good, 1 drop en_in after bin k, 2 index gap after bin k, 3 areset after bin k
  task automatic send_frame(input int mode, input int k, input int idle,
                            input logic [8:0] eb, input logic [32:0] ep);
    @(posedge clk); #1;
    en_in  = 1'b1;
    cnt_in = 9'h1FF;
    din_re = 16'($urandom);
    din_im = 16'($urandom);
    for (int b = 0; b < 512; b++) begin
      @(posedge clk); #1;
      if (mode == 1 && b == k + 1) begin
        en_in = 1'b0;
        err_q.push_back(cyc + 1);
        break;
      end
      if (mode == 3 && b == k + 1) begin
        areset = 1'b1;
        break;
      end
      cnt_in = (mode == 2 && b > k) ? 9'(b + 1) : 9'(b);
      if (mode == 2 && b == k + 1) err_q.push_back(cyc + 1);
      din_re = fr_re[b];
      din_im = fr_im[b];
      if (mode == 0 && b == 511) begin
        exp_cnt = exp_cnt + 16'd1;
        exp_q.push_back('{cyc + 3, eb, ep, exp_cnt});
      end
    end
    if (mode != 3) begin
      @(posedge clk); #1;
      en_in = 1'b0;
    end
    for (int i = 1; i < idle; i++) @(posedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (peak_valid !== 1'b0) begin n_fail++; $display("FAIL reset_peak_valid got=%b exp=0", peak_valid); end
    n_cmp++; if (peak_bin !== 9'd0)   begin n_fail++; $display("FAIL reset_peak_bin got=%0d exp=0", peak_bin); end
    n_cmp++; if (peak_pow !== 33'd0)  begin n_fail++; $display("FAIL reset_peak_pow got=%0d exp=0", peak_pow); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    n_cmp++; if (frame_err !== 1'b0)  begin n_fail++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    @(posedge clk); #1;
    areset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_impulse();
    clear_frame();
    fr_re[37] = 16'sd100;
    fr_im[37] = -16'sd50;
    send_frame(0, 0, 6, 9'd37, 33'd12500);
    @(negedge clk);
    n_cmp++; if (peak_valid !== 1'b0) begin n_fail++; $display("FAIL impulse_pulse_width got=%b exp=0", peak_valid); end
    n_cmp++; if (peak_bin !== 9'd37)  begin n_fail++; $display("FAIL impulse_hold_bin got=%0d exp=37", peak_bin); end
    n_cmp++; if (peak_pow !== 33'd12500) begin n_fail++; $display("FAIL impulse_hold_pow got=%0d exp=12500", peak_pow); end
  endtask

  task automatic test_tie_extreme();
    clear_frame();
    fr_re[5] = 16'sd3;   fr_im[5] = 16'sd4;
    fr_re[200] = 16'sd3; fr_im[200] = 16'sd4;
    send_frame(0, 0, 6, 9'd5, 33'd25);
    clear_frame();
    fr_re[9] = -16'sd32768; fr_im[9] = -16'sd32768;
    fr_re[8] = 16'sd32767;  fr_im[8] = 16'sd32767;
    send_frame(0, 0, 6, 9'd9, 33'h0_8000_0000);
    clear_frame();
    fr_re[511] = 16'sd2;
    send_frame(0, 0, 6, 9'd511, 33'd4);
    clear_frame();
    send_frame(0, 0, 6, SKIP_DC ? 9'd1 : 9'd0, 33'd0);
  endtask

  task automatic test_abort();
    clear_frame();
    fr_re[50] = 16'sd900;
    send_frame(1, 100, 6, 9'd0, 33'd0);
    @(negedge clk);
    n_cmp++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL abort_frame_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    n_cmp++; if (peak_pow !== 33'd0)    begin n_fail++; $display("FAIL abort_hold_pow got=%0d exp=0", peak_pow); end
    clear_frame();
    fr_re[300] = 16'sd7;
    send_frame(0, 0, 6, 9'd300, 33'd49);
  endtask

  task automatic test_gap();
    clear_frame();
    fr_im[400] = 16'sd3000;
    send_frame(2, 10, 6, 9'd0, 33'd0);
    @(negedge clk);
    n_cmp++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL gap_frame_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    n_cmp++; if (peak_bin !== 9'd300)   begin n_fail++; $display("FAIL gap_hold_bin got=%0d exp=300", peak_bin); end
  endtask

  task automatic test_dc();
    clear_frame();
    fr_re[0] = 16'sd1000;
    fr_re[3] = 16'sd10;
    send_frame(0, 0, 6, SKIP_DC ? 9'd3 : 9'd0, SKIP_DC ? 33'd100 : 33'd1000000);
  endtask

  task automatic test_back_to_back();
    logic [8:0]  eb;
    logic [32:0] ep;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 512; i++) begin
        fr_re[i] = 16'($signed(11'($urandom)));
        fr_im[i] = 16'($signed(11'($urandom)));
      end
      if (f == 2) fr_re[511] = 16'sd20000;
      model(eb, ep);
      send_frame(0, 0, (f == 2) ? 8 : 1, eb, ep);
    end
    @(negedge clk);
    n_cmp++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_frame_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    clear_frame();
    fr_re[20] = 16'sd55;
    send_frame(3, 100, 1, 9'd0, 33'd0);
    @(negedge clk);
    n_cmp++; if (peak_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_peak_valid got=%b exp=0", peak_valid); end
    n_cmp++; if (peak_bin !== 9'd0)   begin n_fail++; $display("FAIL midrst_peak_bin got=%0d exp=0", peak_bin); end
    n_cmp++; if (peak_pow !== 33'd0)  begin n_fail++; $display("FAIL midrst_peak_pow got=%0d exp=0", peak_pow); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_frame_cnt got=%0d exp=0", frame_cnt); end
    n_cmp++; if (frame_err !== 1'b0)  begin n_fail++; $display("FAIL midrst_frame_err got=%b exp=0", frame_err); end
    exp_cnt = 16'd0;
    en_in   = 1'b0;
    @(posedge clk); #1;
    areset = 1'b0;
    repeat (2) @(posedge clk);
    send_frame(0, 0, 6, 9'd20, 33'd3025);
  endtask

  initial begin
    areset = 1'b1;
    en_in  = 1'b0;
    cnt_in = 9'd0;
    din_re = 16'sd0;
    din_im = 16'sd0;
    test_reset();
    test_impulse();
    test_tie_extreme();
    test_abort();
    test_gap();
    test_dc();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_peak_valid pending=%0d exp=0", exp_q.size());
    end
    n_cmp++;
    if (err_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_frame_err pending=%0d exp=0", err_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
